// File: rtl/mc_stall_controller.sv
// Multicycle MIPS control unit with a memory ready/request handshake,
// an optional extended instruction set and per-instruction status pulses.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE   | precompute branch target into ALUOut, dispatch on opcode
// MEMADR   | ALUOut <= A + SignImm (load/store address)
// MEMRD    | read data word at ALUOut, wait for memory
// MEMWB    | rt <= data register (lw retires)
// MEMWR    | write B to ALUOut address, wait for memory (sw retires)
// RTYPEEX  | ALUOut <= A op B
// RTYPEWB  | rd <= ALUOut (R-type retires)
// BRANCH   | compare A and B, PC <= ALUOut when taken (beq/bne retire)
// IMMEX    | ALUOut <= A op Imm (sign- or zero-extended)
// IMMWB    | rt <= ALUOut (addi/andi/ori retire)
// JUMP     | PC <= {PC[31:28], IR[25:0], 00} (j retires)

module mc_stall_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit EXT_OPS       = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCEn,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ImmZext,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic [3:0] ALUControl,
  output logic       InstrDone,
  output logic       Illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPEEX, S_RTYPEWB, S_BRANCH, S_IMMEX, S_IMMWB, S_JUMP
  } state_t;

  state_t state, state_nxt;

  logic       rdy;
  logic       is_lw, is_sw, is_rtype, is_beq, is_bne;
  logic       is_addi, is_andi, is_ori, is_j;
  logic       funct_ok, legal;
  logic [3:0] rtype_alu, imm_alu;

  // With the handshake disabled every access completes in one cycle.
  assign rdy = MemReady | ~MEM_HANDSHAKE;

  // Instruction decode; IR is stable from DECODE until the next FETCH.
  always_comb begin
    is_lw    = (Opcode == OP_LW);
    is_sw    = (Opcode == OP_SW);
    is_rtype = (Opcode == OP_RTYPE);
    is_beq   = (Opcode == OP_BEQ);
    is_bne   = EXT_OPS && (Opcode == OP_BNE);
    is_addi  = EXT_OPS && (Opcode == OP_ADDI);
    is_andi  = EXT_OPS && (Opcode == OP_ANDI);
    is_ori   = EXT_OPS && (Opcode == OP_ORI);
    is_j     = EXT_OPS && (Opcode == OP_J);

    funct_ok  = 1'b1;
    rtype_alu = ALU_ADD;
    case (Funct)
      6'b100000: rtype_alu = ALU_ADD;
      6'b100010: rtype_alu = ALU_SUB;
      6'b100100: rtype_alu = ALU_AND;
      6'b100101: rtype_alu = ALU_OR;
      6'b101010: rtype_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase

    imm_alu = ALU_ADD;
    if (is_andi)     imm_alu = ALU_AND;
    else if (is_ori) imm_alu = ALU_OR;

    legal = is_lw | is_sw | (is_rtype & funct_ok) | is_beq | is_bne |
            is_addi | is_andi | is_ori | is_j;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Next-state and output decode; strobes are forced low while in reset.
  always_comb begin
    state_nxt  = state;
    MemReq     = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCEn       = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ImmZext    = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    ALUControl = ALU_ADD;
    InstrDone  = 1'b0;
    Illegal    = 1'b0;

    case (state)
      S_FETCH: begin
        MemReq  = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = rdy;
        PCEn    = rdy;
        if (rdy) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        if (!legal) begin
          Illegal   = 1'b1;
          state_nxt = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_nxt = S_MEMADR;
        end else if (is_rtype) begin
          state_nxt = S_RTYPEEX;
        end else if (is_beq || is_bne) begin
          state_nxt = S_BRANCH;
        end else if (is_j) begin
          state_nxt = S_JUMP;
        end else begin
          state_nxt = S_IMMEX;
        end
      end
      S_MEMADR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        state_nxt = is_lw ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemReq = 1'b1;
        IorD   = 1'b1;
        if (rdy) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        MemToReg  = 1'b1;
        InstrDone = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWR: begin
        MemReq   = 1'b1;
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (rdy) begin
          InstrDone = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_RTYPEEX: begin
        ALUSrcA    = 1'b1;
        ALUControl = rtype_alu;
        state_nxt  = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        RegWrite  = 1'b1;
        RegDst    = 1'b1;
        InstrDone = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        PCEn       = is_bne ? ~Zero : Zero;
        InstrDone  = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_IMMEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ImmZext    = is_andi | is_ori;
        ALUControl = imm_alu;
        state_nxt  = S_IMMWB;
      end
      S_IMMWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JUMP: begin
        PCSrc     = 2'b10;
        PCEn      = 1'b1;
        InstrDone = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase

    if (reset) begin
      PCEn      = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
      MemReq    = 1'b0;
      InstrDone = 1'b0;
      Illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_stall_controller.sv
// Bench for mc_stall_controller: per-instruction cycle expectations built
// from the phase rules of each instruction class, compared every cycle.
// Instance 0: handshake and extended ops on. Instance 1: both off.

module tb_mc_stall_controller;

  localparam logic [3:0] A_AND = 4'b0000;
  localparam logic [3:0] A_OR  = 4'b0001;
  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110;
  localparam logic [3:0] A_SLT = 4'b0111;

  typedef struct packed {
    logic       memreq, iord, memwrite, irwrite, pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       immzext, regwrite, regdst, memtoreg;
    logic [3:0] aluctl;
    logic       done, illegal;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, reset2;
  logic [5:0] Opcode, Funct, op2, fn2;
  logic       Zero, MemReady, zr2, mr2;

  logic       MemReq, IorD, MemWrite, IRWrite, PCEn, ALUSrcA, ImmZext;
  logic       RegWrite, RegDst, MemToReg, InstrDone, Illegal;
  logic [1:0] PCSrc, ALUSrcB;
  logic [3:0] ALUControl;

  logic       MemReq2, IorD2, MemWrite2, IRWrite2, PCEn2, ALUSrcA2, ImmZext2;
  logic       RegWrite2, RegDst2, MemToReg2, InstrDone2, Illegal2;
  logic [1:0] PCSrc2, ALUSrcB2;
  logic [3:0] ALUControl2;

  mc_stall_controller #(.MEM_HANDSHAKE(1'b1), .EXT_OPS(1'b1)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .MemReq(MemReq), .IorD(IorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCEn(PCEn), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmZext(ImmZext), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemToReg(MemToReg), .ALUControl(ALUControl), .InstrDone(InstrDone),
    .Illegal(Illegal)
  );

  mc_stall_controller #(.MEM_HANDSHAKE(1'b0), .EXT_OPS(1'b0)) dut_fixed (
    .clk(clk), .reset(reset2), .Opcode(op2), .Funct(fn2), .Zero(zr2),
    .MemReady(mr2), .MemReq(MemReq2), .IorD(IorD2), .MemWrite(MemWrite2),
    .IRWrite(IRWrite2), .PCEn(PCEn2), .PCSrc(PCSrc2), .ALUSrcA(ALUSrcA2),
    .ALUSrcB(ALUSrcB2), .ImmZext(ImmZext2), .RegWrite(RegWrite2), .RegDst(RegDst2),
    .MemToReg(MemToReg2), .ALUControl(ALUControl2), .InstrDone(InstrDone2),
    .Illegal(Illegal2)
  );

  exp_t obs0, obs1;
  assign obs0 = {MemReq, IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
                 ImmZext, RegWrite, RegDst, MemToReg, ALUControl, InstrDone, Illegal};
  assign obs1 = {MemReq2, IorD2, MemWrite2, IRWrite2, PCEn2, PCSrc2, ALUSrcA2, ALUSrcB2,
                 ImmZext2, RegWrite2, RegDst2, MemToReg2, ALUControl2, InstrDone2, Illegal2};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  exp_t exp_q[$];
  logic mr_q[$];

  function automatic exp_t blank();
    exp_t e;
    e = '0;
    e.aluctl = A_ADD;
    return e;
  endfunction

  function automatic logic rnd1();
    return 1'($urandom);
  endfunction

  // Builds the expected cycle-by-cycle outputs (and MemReady to drive) for one
  // instruction; returns how many InstrDone pulses it should produce.
  task automatic plan(input bit ext, input bit hs, input logic [5:0] op,
                      input logic [5:0] fn, input logic z, input int fw_in,
                      input int mw_in, output int ndone);
    exp_t e;
    int fw, mw;
    bit lw, sw, rt, fok, beq, bne, imm, jj, zx, legal;
    logic [3:0] rfn, ifn;
    fw = hs ? fw_in : 0;
    mw = hs ? mw_in : 0;
    lw = (op == 6'b100011);
    sw = (op == 6'b101011);
    rt = (op == 6'b000000);
    beq = (op == 6'b000100);
    bne = ext && (op == 6'b000101);
    jj  = ext && (op == 6'b000010);
    imm = ext && (op == 6'b001000 || op == 6'b001100 || op == 6'b001101);
    zx  = ext && (op == 6'b001100 || op == 6'b001101);
    ifn = (op == 6'b001100) ? A_AND : (op == 6'b001101) ? A_OR : A_ADD;
    fok = 1'b1;
    case (fn)
      6'b100000: rfn = A_ADD;
      6'b100010: rfn = A_SUB;
      6'b100100: rfn = A_AND;
      6'b100101: rfn = A_OR;
      6'b101010: rfn = A_SLT;
      default: begin rfn = A_ADD; fok = 1'b0; end
    endcase
    legal = lw || sw || (rt && fok) || beq || bne || imm || jj;
    ndone = legal ? 1 : 0;

    for (int i = 0; i <= fw; i++) begin
      e = blank(); e.memreq = 1; e.alusrcb = 2'b01;
      e.irwrite = (i == fw); e.pcen = (i == fw);
      exp_q.push_back(e); mr_q.push_back(hs ? (i == fw) : rnd1());
    end
    e = blank(); e.alusrcb = 2'b11; e.illegal = !legal;
    exp_q.push_back(e); mr_q.push_back(rnd1());
    if (!legal) return;

    if (lw || sw) begin
      e = blank(); e.alusrca = 1; e.alusrcb = 2'b10;
      exp_q.push_back(e); mr_q.push_back(rnd1());
      for (int i = 0; i <= mw; i++) begin
        e = blank(); e.memreq = 1; e.iord = 1;
        e.memwrite = sw; e.done = sw && (i == mw);
        exp_q.push_back(e); mr_q.push_back(hs ? (i == mw) : rnd1());
      end
      if (lw) begin
        e = blank(); e.regwrite = 1; e.memtoreg = 1; e.done = 1;
        exp_q.push_back(e); mr_q.push_back(rnd1());
      end
    end else if (rt) begin
      e = blank(); e.alusrca = 1; e.aluctl = rfn;
      exp_q.push_back(e); mr_q.push_back(rnd1());
      e = blank(); e.regwrite = 1; e.regdst = 1; e.done = 1;
      exp_q.push_back(e); mr_q.push_back(rnd1());
    end else if (beq || bne) begin
      e = blank(); e.alusrca = 1; e.aluctl = A_SUB; e.pcsrc = 2'b01; e.done = 1;
      e.pcen = beq ? z : !z;
      exp_q.push_back(e); mr_q.push_back(rnd1());
    end else if (imm) begin
      e = blank(); e.alusrca = 1; e.alusrcb = 2'b10; e.immzext = zx; e.aluctl = ifn;
      exp_q.push_back(e); mr_q.push_back(rnd1());
      e = blank(); e.regwrite = 1; e.done = 1;
      exp_q.push_back(e); mr_q.push_back(rnd1());
    end else begin
      e = blank(); e.pcsrc = 2'b10; e.pcen = 1; e.done = 1;
      exp_q.push_back(e); mr_q.push_back(rnd1());
    end
  endtask

  // Entered #1 after a rising edge with the selected DUT in FETCH; leaves the
  // same way after the instruction has retired.
  task automatic run_instr(input bit which, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int fw, input int mw);
    exp_t e, got;
    logic m;
    int exp_done, ndone, cyc;
    plan(!which, !which, op, fn, z, fw, mw, exp_done);
    ndone = 0;
    cyc = 0;
    if (which) begin op2 = op; fn2 = fn; zr2 = z; end
    else       begin Opcode = op; Funct = fn; Zero = z; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m = mr_q.pop_front();
      if (which) mr2 = m; else MemReady = m;
      @(negedge clk);
      got = which ? obs1 : obs0;
      check($sformatf("u%0d op=%b fn=%b cyc%0d", which, op, fn, cyc), {12'b0, got}, {12'b0, e});
      ndone += int'(got.done);
      cyc++;
      @(posedge clk); #1;
    end
    check($sformatf("u%0d op=%b done_count", which, op), 32'(ndone), 32'(exp_done));
  endtask

  logic [5:0] op_tab [10];
  logic [5:0] fn_tab [6];
  exp_t fetch_wait;

  initial begin
    op_tab = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
               6'b001000, 6'b001100, 6'b001101, 6'b000010, 6'b111111};
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    reset = 1; reset2 = 1;
    Opcode = 6'b100011; Funct = 0; Zero = 0; MemReady = 1;
    op2 = 0; fn2 = 6'b100000; zr2 = 0; mr2 = 1;

    // Reset holds all strobes low even though FETCH would see MemReady=1.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_strobes",
            {25'b0, MemReq, IRWrite, PCEn, RegWrite, MemWrite, InstrDone, Illegal}, 32'b0);
    end
    @(posedge clk); #1;
    reset = 0;

    // Directed scenarios.
    run_instr(0, 6'b100011, 6'd0, 1'b0, 0, 0);          // lw, no waits
    run_instr(0, 6'b000000, 6'b100000, 1'b0, 3, 0);     // add, 3 fetch waits
    run_instr(0, 6'b101011, 6'd0, 1'b0, 0, 2);          // sw, 2 write waits
    run_instr(0, 6'b000100, 6'd0, 1'b1, 0, 0);          // beq taken
    run_instr(0, 6'b000101, 6'd0, 1'b1, 0, 0);          // bne not taken
    run_instr(0, 6'b001101, 6'd0, 1'b0, 0, 0);          // ori
    run_instr(0, 6'b000000, 6'b000111, 1'b0, 0, 0);     // illegal funct
    run_instr(0, 6'b000010, 6'd0, 1'b0, 1, 0);          // j

    // Randomized instruction stream with random wait states.
    for (int k = 0; k < 80; k++) begin
      run_instr(0, op_tab[$urandom_range(0, 9)], fn_tab[$urandom_range(0, 5)],
                rnd1(), ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : 0,
                ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : 0);
    end

    // Reset during a MEMWR stall abandons the write.
    Opcode = 6'b101011; MemReady = 1;
    @(posedge clk); #1;                        // DECODE
    @(posedge clk); #1;                        // MEMADR
    @(posedge clk); #1; MemReady = 0;          // MEMWR, stalled
    @(negedge clk);
    check("memwr_stall_strobe", {31'b0, MemWrite}, 32'd1);
    @(posedge clk); #1; reset = 1;             // still MEMWR, reset asserted
    @(negedge clk);
    check("memwr_reset_strobe", {30'b0, MemWrite, MemReq}, 32'd0);
    @(posedge clk); #1; reset = 0;             // back in FETCH
    @(negedge clk);
    fetch_wait = blank(); fetch_wait.memreq = 1; fetch_wait.alusrcb = 2'b01;
    check("after_reset_fetch", {12'b0, obs0}, {12'b0, fetch_wait});
    @(posedge clk); #1;
    run_instr(0, 6'b100011, 6'd0, 1'b0, 1, 1);

    // Fixed-latency, base-ISA instance: MemReady ignored, extended ops illegal.
    reset2 = 0;
    run_instr(1, 6'b000010, 6'd0, 1'b0, 0, 0);          // j -> illegal
    mr2 = 0;
    run_instr(1, 6'b100011, 6'd0, 1'b0, 0, 0);          // lw, ready low ignored
    run_instr(1, 6'b001101, 6'd0, 1'b0, 0, 0);          // ori -> illegal
    run_instr(1, 6'b000101, 6'd0, 1'b0, 0, 0);          // bne -> illegal
    run_instr(1, 6'b101011, 6'd0, 1'b0, 0, 0);          // sw
    for (int k = 0; k < 20; k++) begin
      run_instr(1, op_tab[$urandom_range(0, 9)], fn_tab[$urandom_range(0, 5)],
                rnd1(), 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
